// File: rtl/t03_load_store_unit.sv
// rtl/t03_load_store_unit.sv - load/store unit bridging pipeline memory ops to a word bus
// Single outstanding access; lane steering on issue, extraction and extension on ack.
module t03_load_store_unit #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cycle_cnt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;

    logic        req;
    logic        req_illegal;
    logic        req_misaligned;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    assign req   = memRead | memWrite;
    assign stall = (state == ACCESS) || ((state == IDLE) && req);

    // Unsigned variants only exist for loads, so 1xx on a store is illegal too.
    assign req_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (memWrite && funct3[2]);
    assign req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                            ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        req_sel   = 4'b1111;
        req_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                req_sel   = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_sel   = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata[15:0]}};
            end
            default: begin
                req_sel   = 4'b1111;
                req_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte  = bus_rdata[7:0];
        case (addr_lo_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half  = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ext_data = {24'b0, rd_byte};
            3'b101:  ext_data = {16'b0, rd_half};
            default: ext_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cycle_cnt  <= 8'd0;
            addr_lo_q  <= 2'd0;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_sel    <= 4'd0;
            load_data  <= 32'd0;
            done       <= 1'b0;
            fault      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 2'b00;
                    if (req) begin
                        addr_lo_q  <= addr[1:0];
                        funct3_q   <= funct3;
                        is_store_q <= memWrite;
                        if (req_illegal || req_misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= req_illegal ? 2'b11 : 2'b01;
                        end else begin
                            state     <= ACCESS;
                            cycle_cnt <= 8'd0;
                            bus_read  <= ~memWrite;
                            bus_write <= memWrite;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_sel   <= req_sel;
                            bus_wdata <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // An ack landing on the final counted cycle still counts as success.
                    if (bus_ack || (cycle_cnt == TO_LAST)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        fault     <= bus_ack ? 2'b00 : 2'b10;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_sel   <= 4'd0;
                        bus_wdata <= 32'd0;
                        if (!is_store_q) begin
                            load_data <= bus_ack ? ext_data : 32'd0;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_load_store_unit.sv
// tb/tb_t03_load_store_unit.sv - randomized self-checking bench for t03_load_store_unit
module tb_t03_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic        bus_ack;
    logic        bus_read, bus_write;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_sel;
    logic        done, stall;
    logic [1:0]  fault;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ld_model = 32'd0;

    t03_load_store_unit #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_read(bus_read), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .load_data(load_data), .done(done), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return {24'd0, sh[7:0]};
            3'd5:    return {16'd0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // One request from IDLE to completion; ack_at is the ACCESS cycle (1-based) that sees ack, 0 = never.
    task automatic run_txn(input logic st, input logic rd_too, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd);
        logic        illegal, misal;
        int          nbytes, n_acc;
        logic [1:0]  exp_fault;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wd;
        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3 >= 3'd4);
        misal   = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        exp_sel = (nbytes == 4) ? 4'hF : (((nbytes == 2) ? 4'b0011 : 4'b0001) << a[1:0]);
        exp_wd  = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;

        @(negedge clk);
        memRead = st ? rd_too : 1'b1; memWrite = st; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL req_stall: got %b want 1", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL req_done: got %b want 0", done); end
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        if (illegal || misal) begin
            exp_fault = illegal ? 2'b11 : 2'b01;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL flt_done: got %b want 1", done); end
            checks++; if (fault !== exp_fault) begin errors++; $display("FAIL flt_cause: got %b want %b", fault, exp_fault); end
            checks++; if ({bus_read, bus_write} !== 2'b00) begin errors++; $display("FAIL flt_strobe: got %b want 00", {bus_read, bus_write}); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flt_stall: got %b want 0", stall); end
            checks++; if (load_data !== ld_model) begin errors++; $display("FAIL flt_load: got %h want %h", load_data, ld_model); end
        end else begin
            n_acc     = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
            exp_fault = (ack_at >= 1 && ack_at <= TO) ? 2'b00 : 2'b10;
            for (int k = 1; k <= n_acc; k++) begin
                checks++; if (done !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL acc_ctl c%0d: done=%b stall=%b want 0/1", k, done, stall); end
                checks++; if ({bus_read, bus_write} !== {~st, st}) begin errors++; $display("FAIL acc_strobe c%0d: got %b want %b", k, {bus_read, bus_write}, {~st, st}); end
                checks++; if (bus_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL acc_addr c%0d: got %h want %h", k, bus_addr, {a[31:2], 2'b00}); end
                checks++; if (bus_sel !== exp_sel) begin errors++; $display("FAIL acc_sel c%0d: got %b want %b", k, bus_sel, exp_sel); end
                checks++; if (bus_wdata !== exp_wd) begin errors++; $display("FAIL acc_wdata c%0d: got %h want %h", k, bus_wdata, exp_wd); end
                if (k == n_acc && exp_fault == 2'b00) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end else begin
                    bus_ack = 1'b0; bus_rdata = $urandom;
                end
                @(negedge clk);
            end
            bus_ack = 1'b0;
            if (!st) ld_model = (exp_fault == 2'b00) ? ext_model(f3, a, rd) : 32'd0;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done: got %b want 1", done); end
            checks++; if (fault !== exp_fault) begin errors++; $display("FAIL end_fault: got %b want %b", fault, exp_fault); end
            checks++; if (load_data !== ld_model) begin errors++; $display("FAIL end_load: got %h want %h", load_data, ld_model); end
            checks++; if ({bus_read, bus_write, stall} !== 3'b000) begin errors++; $display("FAIL end_idle: rd/wr/stall got %b want 000", {bus_read, bus_write, stall}); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset;
        rst = 1'b1; memRead = 0; memWrite = 0; funct3 = 0; addr = 0; wdata = 0; bus_rdata = 0; bus_ack = 0;
        repeat (2) @(negedge clk);
        checks++; if ({bus_read, bus_write, done, stall, fault} !== 6'd0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {bus_read, bus_write, done, stall, fault}); end
        checks++; if ({bus_addr, bus_wdata, bus_sel, load_data} !== 100'd0) begin errors++; $display("FAIL reset_data: addr=%h wdata=%h sel=%b ld=%h want 0", bus_addr, bus_wdata, bus_sel, load_data); end
        rst = 1'b0;
        ld_model = 32'd0;
    endtask

    task automatic test_lb_sign;
        run_txn(1'b0, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000);
        checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value: got %h want ffffff80", load_data); end
    endtask

    task automatic test_sh_store;
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0);
        checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_keeps_load: got %h want ffffff80", load_data); end
    endtask

    task automatic test_misaligned;
        run_txn(1'b0, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1, 32'h0);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0000, 32'h0, 1, 32'h0);
        run_txn(1'b0, 1'b0, 3'b111, 32'h0000_0000, 32'h0, 1, 32'h0);
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0);
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL timeout_zero: got %h want 0", load_data); end
        run_txn(1'b0, 1'b0, 3'b010, 32'h0000_0044, 32'h0, TO, 32'hCAFE_F00D);
    endtask

    task automatic test_ack_ignored_idle;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++; if ({done, bus_read, bus_write} !== 3'b000 || load_data !== ld_model) begin errors++; $display("FAIL idle_ack: done=%b ld=%h want 0/%h", done, load_data, ld_model); end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        memRead = 1'b1; funct3 = 3'b101; addr = 32'h0000_0002;
        @(negedge clk);
        memRead = 1'b0;
        checks++; if (bus_read !== 1'b1) begin errors++; $display("FAIL abort_rd: got %b want 1", bus_read); end
        @(negedge clk);
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0; bus_ack = 1'b0;
        ld_model = 32'd0;
        checks++; if ({bus_read, bus_write, done, stall, fault, bus_sel} !== 10'd0) begin errors++; $display("FAIL abort_ctl: got %b want 0", {bus_read, bus_write, done, stall, fault, bus_sel}); end
        checks++; if ({bus_addr, bus_wdata, load_data} !== 96'd0) begin errors++; $display("FAIL abort_data: addr=%h ld=%h want 0", bus_addr, load_data); end
        run_txn(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'h1357_9BDF);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
                    $urandom_range(0, TO + 1), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_store();
        test_misaligned();
        test_timeout();
        test_ack_ignored_idle();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t03_load_store_unit.md
T03_LOAD_STORE_UNIT -- requirements
Module: t03_load_store_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: max ACCESS cycles to wait for bus_ack before timeout fault (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port memRead, input, 1, load request from control, sampled in IDLE only.
REQ-005 SHALL have port memWrite, input, 1, store request from control, sampled in IDLE only.
REQ-006 SHALL have port funct3, input, 3, access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 SHALL have port addr, input, 32, byte address; this is the ALU result.
REQ-008 SHALL have port wdata, input, 32, store data; this is rd2.
REQ-009 SHALL have port bus_rdata, input, 32, word read data, valid with bus_ack.
REQ-010 SHALL have port bus_ack, input, 1, completion of the current bus access.
REQ-011 SHALL have port bus_read, output, 1, read strobe.
REQ-012 SHALL have port bus_write, output, 1, write strobe.
REQ-013 SHALL have port bus_addr, output, 32, word-aligned address {addr[31:2],2'b00}.
REQ-014 SHALL have port bus_wdata, output, 32, lane-replicated store data.
REQ-015 SHALL have port bus_sel, output, 4, byte-lane enables.
REQ-016 SHALL have port load_data, output, 32, extended load result.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port stall, output, 1, freezes the pipeline while an access is pending.
REQ-019 SHALL have port fault, output, 2, cause valid with done: 00 none, 01 misaligned, 10 timeout, 11 illegal funct3.

Function
REQ-020 SHALL implement the states IDLE, ACCESS and DONE.
REQ-021 In IDLE with memRead or memWrite high, the unit SHALL latch addr, wdata, funct3 and direction; memWrite wins if both are high.
REQ-022 Legal, aligned request: IDLE->ACCESS. Misaligned or illegal funct3 (011, 110, 111; or 1xx on a store): IDLE->DONE with no bus strobe.
REQ-023 Misaligned means: half with addr[0]=1, or word with addr[1:0]!=00.
REQ-024 In ACCESS, exactly one of bus_read/bus_write SHALL be high each cycle; bus_addr, bus_sel and bus_wdata SHALL be held stable.
REQ-025 Lanes: byte sel=1<<addr[1:0], data={4{wdata[7:0]}}; half sel=addr[1]?1100:0011, data={2{wdata[15:0]}}; word sel=1111, data=wdata.
REQ-026 ACCESS with bus_ack high SHALL go to DONE and register load_data from bus_rdata; the byte/half is selected by the latched addr[1:0], sign-extended for 000/001 and zero-extended for 100/101.
REQ-027 A cycle counter SHALL clear on ACCESS entry; if BUS_TIMEOUT ACCESS cycles elapse with no ack, the unit SHALL go to DONE with fault=10 and load_data=0.
REQ-028 An ack in the same cycle the count expires SHALL win: fault=00 and the data is captured.
REQ-029 DONE SHALL last exactly one cycle with done=1 and fault valid, then return to IDLE; load_data SHALL hold until the next completed load.
REQ-030 Stores SHALL leave load_data unchanged.
REQ-031 stall SHALL be combinational: 1 in ACCESS, 1 in IDLE when memRead|memWrite, and 0 in DONE and in idle IDLE.
REQ-032 memRead/memWrite SHALL be ignored in ACCESS and DONE.
REQ-033 Latency: with ack in the first ACCESS cycle, done is asserted 2 cycles after the request cycle.
REQ-034 bus_ack outside ACCESS SHALL be ignored.

Reset
REQ-035 With rst high at a clock edge, the unit SHALL enter IDLE, clear the counter, and drive bus_read, bus_write, bus_sel, bus_addr, bus_wdata, load_data, done, stall (absent requests) and fault to 0.
REQ-036 rst SHALL take priority over every transition; reset during ACCESS aborts the access with no done pulse, and strobes drop after that edge.

Verification
REQ-037 LB, addr=0x1003, bus_rdata=0x80FF_0000, ack in first ACCESS cycle -> bus_sel=1000, bus_addr=0x1000, load_data=0xFFFF_FF80, done 2 cycles after request, fault=00.
REQ-038 SH, addr=0x2002, wdata=0x1234_ABCD, ack after 3 cycles -> bus_write for 3 cycles, bus_sel=1100, bus_wdata=0xABCD_ABCD, load_data unchanged.
REQ-039 LW, addr=0x0006 -> no strobe, next cycle done=1 with fault=01; stall high only in the request cycle.
REQ-040 LW, BUS_TIMEOUT=4, no ack -> 4 ACCESS cycles, then done with fault=10 and load_data=0; repeat with ack on the 4th cycle -> fault=00.
REQ-041 LHU, addr=0x0002, rst asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, no done; a new LW then completes normally.
